// File: rtl/axi_wb_pkg.sv
// Shared types and helpers for the AXI4-slave to Wishbone-classic-master bridge:
// FSM states, burst/response encodings and burst address sequencing.
package axi_wb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_BUS,
      RD_RESP,
      WR_DATA,
      WR_BUS,
      WR_RESP
   } state_t;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Address of the following beat. WRAP only wraps for legal lengths (2/4/8/16
   // beats); any other WRAP length, and the reserved encoding, behave as INCR.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [7:0]  len,
                                             input logic [1:0]  burst);
      logic [31:0] incr;
      logic [31:0] mask;
      logic [31:0] result;
      incr   = addr + 32'd4;
      mask   = {22'd0, len, 2'b11};
      result = incr;
      if (burst == BURST_FIXED) begin
         result = addr;
      end else if (burst == BURST_WRAP &&
                   (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
         result = (addr & ~mask) | (incr & mask);
      end
      return result;
   endfunction

endpackage

// File: rtl/axi4_wishbone_bridge.sv
// AXI4 slave to Wishbone classic master bridge: one outstanding burst, beats
// are issued one at a time on Wishbone with an optional per-beat ack timeout.
module axi4_wishbone_bridge
   import axi_wb_pkg::*;
#(
   parameter int ID_W           = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int STRB_W        = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              axi_awvalid_i,
   output logic              axi_awready_o,
   input  logic [ADDR_W-1:0] axi_awaddr_i,
   input  logic [ID_W-1:0]   axi_awid_i,
   input  logic [7:0]        axi_awlen_i,
   input  logic [1:0]        axi_awburst_i,

   input  logic              axi_wvalid_i,
   output logic              axi_wready_o,
   input  logic [DATA_W-1:0] axi_wdata_i,
   input  logic [STRB_W-1:0] axi_wstrb_i,
   input  logic              axi_wlast_i,

   output logic              axi_bvalid_o,
   input  logic              axi_bready_i,
   output logic [1:0]        axi_bresp_o,
   output logic [ID_W-1:0]   axi_bid_o,

   input  logic              axi_arvalid_i,
   output logic              axi_arready_o,
   input  logic [ADDR_W-1:0] axi_araddr_i,
   input  logic [ID_W-1:0]   axi_arid_i,
   input  logic [7:0]        axi_arlen_i,
   input  logic [1:0]        axi_arburst_i,

   output logic              axi_rvalid_o,
   input  logic              axi_rready_i,
   output logic [DATA_W-1:0] axi_rdata_o,
   output logic [1:0]        axi_rresp_o,
   output logic [ID_W-1:0]   axi_rid_o,
   output logic              axi_rlast_o,

   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [STRB_W-1:0] wb_sel_o,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              wb_ack_i
);

   localparam int TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [ID_W-1:0]     id_reg;
   logic [7:0]          len_reg;
   logic [1:0]          burst_reg;
   logic [7:0]          beat_reg;
   logic                err_reg;
   logic                pref_wr_reg;
   logic [DATA_W-1:0]   rdata_reg;
   logic [1:0]          rresp_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic [STRB_W-1:0]   wstrb_reg;
   logic [TMO_W-1:0]    tmo_cnt_reg;

   logic                grant_wr;
   logic                grant_rd;
   logic                last_beat;
   logic                bus_active;
   logic                tmo_fire;
   logic [ADDR_W-1:0]   addr_adv;

   // A tie between AW and AR goes to whichever channel was not served last.
   assign grant_wr   = axi_awvalid_i && (!axi_arvalid_i || pref_wr_reg);
   assign grant_rd   = axi_arvalid_i && !grant_wr;
   assign last_beat  = (beat_reg == len_reg);
   assign bus_active = (state_reg == RD_BUS) || (state_reg == WR_BUS);
   assign tmo_fire   = (TIMEOUT_CYCLES != 0) && bus_active && !wb_ack_i &&
                       (tmo_cnt_reg == TMO_W'(TMO_LAST));
   assign addr_adv   = ADDR_W'(next_addr(32'(addr_reg), len_reg, burst_reg));

   assign axi_rdata_o = rdata_reg;
   assign axi_rresp_o = rresp_reg;
   assign axi_rid_o   = id_reg;
   assign axi_rlast_o = (state_reg == RD_RESP) && last_beat;
   assign axi_bid_o   = id_reg;
   assign axi_bresp_o = err_reg ? RESP_SLVERR : RESP_OKAY;
   assign wb_addr_o   = {addr_reg[ADDR_W-1:2], 2'b00};
   assign wb_data_o   = wdata_reg;

   always_comb begin
      state_next    = state_reg;
      axi_awready_o = 1'b0;
      axi_arready_o = 1'b0;
      axi_wready_o  = 1'b0;
      axi_bvalid_o  = 1'b0;
      axi_rvalid_o  = 1'b0;
      wb_cyc_o      = 1'b0;
      wb_stb_o      = 1'b0;
      wb_we_o       = 1'b0;
      wb_sel_o      = '0;
      case (state_reg)
         IDLE: begin
            axi_awready_o = grant_wr;
            axi_arready_o = grant_rd;
            if (grant_wr)      state_next = WR_DATA;
            else if (grant_rd) state_next = RD_BUS;
         end
         RD_BUS: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_sel_o = '1;
            if (wb_ack_i || tmo_fire) state_next = RD_RESP;
         end
         RD_RESP: begin
            axi_rvalid_o = 1'b1;
            if (axi_rready_i) state_next = last_beat ? IDLE : RD_BUS;
         end
         WR_DATA: begin
            axi_wready_o = 1'b1;
            if (axi_wvalid_i) state_next = WR_BUS;
         end
         WR_BUS: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = 1'b1;
            wb_sel_o = wstrb_reg;
            if (wb_ack_i || tmo_fire) state_next = last_beat ? WR_RESP : WR_DATA;
         end
         WR_RESP: begin
            axi_bvalid_o = 1'b1;
            if (axi_bready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         id_reg      <= '0;
         len_reg     <= '0;
         burst_reg   <= '0;
         beat_reg    <= '0;
         err_reg     <= 1'b0;
         pref_wr_reg <= 1'b1;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         tmo_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         // Counter restarts on every new strobe and only runs while unacked.
         if (bus_active && !wb_ack_i && !tmo_fire) tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
         else                                      tmo_cnt_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (grant_wr) begin
                  addr_reg    <= axi_awaddr_i;
                  id_reg      <= axi_awid_i;
                  len_reg     <= axi_awlen_i;
                  burst_reg   <= axi_awburst_i;
                  beat_reg    <= '0;
                  err_reg     <= 1'b0;
                  pref_wr_reg <= 1'b0;
               end else if (grant_rd) begin
                  addr_reg    <= axi_araddr_i;
                  id_reg      <= axi_arid_i;
                  len_reg     <= axi_arlen_i;
                  burst_reg   <= axi_arburst_i;
                  beat_reg    <= '0;
                  err_reg     <= 1'b0;
                  pref_wr_reg <= 1'b1;
               end
            end
            RD_BUS: begin
               if (wb_ack_i) begin
                  rdata_reg <= wb_data_i;
                  rresp_reg <= RESP_OKAY;
               end else if (tmo_fire) begin
                  rdata_reg <= '0;
                  rresp_reg <= RESP_SLVERR;
               end
            end
            RD_RESP: begin
               if (axi_rready_i && !last_beat) begin
                  addr_reg <= addr_adv;
                  beat_reg <= beat_reg + 8'd1;
               end
            end
            WR_DATA: begin
               if (axi_wvalid_i) begin
                  wdata_reg <= axi_wdata_i;
                  wstrb_reg <= axi_wstrb_i;
                  if (axi_wlast_i != last_beat) err_reg <= 1'b1;
               end
            end
            WR_BUS: begin
               if (tmo_fire) err_reg <= 1'b1;
               if ((wb_ack_i || tmo_fire) && !last_beat) begin
                  addr_reg <= addr_adv;
                  beat_reg <= beat_reg + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_wishbone_bridge.sv
// Directed bench for axi4_wishbone_bridge: AXI master driver tasks plus a
// Wishbone slave with programmable wait states that logs every acked beat.
module tb_axi4_wishbone_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        axi_awvalid_i = 1'b0;
   logic        axi_awready_o;
   logic [31:0] axi_awaddr_i = '0;
   logic [3:0]  axi_awid_i = '0;
   logic [7:0]  axi_awlen_i = '0;
   logic [1:0]  axi_awburst_i = '0;
   logic        axi_wvalid_i = 1'b0;
   logic        axi_wready_o;
   logic [31:0] axi_wdata_i = '0;
   logic [3:0]  axi_wstrb_i = '0;
   logic        axi_wlast_i = 1'b0;
   logic        axi_bvalid_o;
   logic        axi_bready_i = 1'b0;
   logic [1:0]  axi_bresp_o;
   logic [3:0]  axi_bid_o;
   logic        axi_arvalid_i = 1'b0;
   logic        axi_arready_o;
   logic [31:0] axi_araddr_i = '0;
   logic [3:0]  axi_arid_i = '0;
   logic [7:0]  axi_arlen_i = '0;
   logic [1:0]  axi_arburst_i = '0;
   logic        axi_rvalid_o;
   logic        axi_rready_i = 1'b0;
   logic [31:0] axi_rdata_o;
   logic [1:0]  axi_rresp_o;
   logic [3:0]  axi_rid_o;
   logic        axi_rlast_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_data_i = '0;
   logic        wb_ack_i = 1'b0;

   int total = 0;
   int bad = 0;
   bit hung = 1'b0;

   // Slave configuration and logs
   int          wait_cfg = 0;
   bit          slave_en = 1'b1;
   bit          rd_fixed = 1'b1;
   int          ack_cnt = 0;
   int          stb_cycles = 0;
   int          ncyc = 0;
   logic [31:0] q_addr[$];
   logic [3:0]  q_sel[$];
   logic        q_we[$];
   logic [31:0] q_data[$];

   // Captured R beats
   logic [31:0] r_data[16];
   logic [1:0]  r_resp[16];
   logic        r_last[16];
   logic [3:0]  r_id[16];
   int          r_n = 0;
   int          r_last_cyc = 0;

   localparam logic [31:0] WRAP_EXP [8] = '{32'h2018, 32'h201C, 32'h2000, 32'h2004,
                                            32'h2008, 32'h200C, 32'h2010, 32'h2014};

   axi4_wishbone_bridge #(
      .ID_W(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
      .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
      .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
      .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
      .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
      .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
      .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
      .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
      .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
      .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
      .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
      .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
      .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
      .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ncyc <= ncyc + 1;

   // Wishbone slave: ack after wait_cfg wait cycles, decided on the falling edge.
   always @(negedge clk) begin
      if (wb_cyc_o && wb_stb_o) begin
         stb_cycles <= stb_cycles + 1;
         if (slave_en && ack_cnt == wait_cfg) begin
            wb_ack_i  <= 1'b1;
            wb_data_i <= rd_fixed ? 32'hDEADBEEF : (wb_addr_o ^ 32'h5A5A0000);
            ack_cnt   <= 0;
            q_addr.push_back(wb_addr_o);
            q_sel.push_back(wb_sel_o);
            q_we.push_back(wb_we_o);
            q_data.push_back(wb_data_o);
         end else begin
            wb_ack_i <= 1'b0;
            ack_cnt  <= ack_cnt + 1;
         end
      end else begin
         wb_ack_i <= 1'b0;
         ack_cnt  <= 0;
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic axi_ar(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
      bit ok = 1'b0;
      axi_arvalid_i = 1'b1; axi_araddr_i = a; axi_arid_i = id;
      axi_arlen_i = len; axi_arburst_i = burst;
      for (int c = 0; c < 100 && !ok; c++) begin
         #1 ok = axi_arready_o;
         @(negedge clk);
      end
      axi_arvalid_i = 1'b0;
      if (!ok) hung = 1'b1;
   endtask

   task automatic axi_aw(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst);
      bit ok = 1'b0;
      axi_awvalid_i = 1'b1; axi_awaddr_i = a; axi_awid_i = id;
      axi_awlen_i = len; axi_awburst_i = burst;
      for (int c = 0; c < 100 && !ok; c++) begin
         #1 ok = axi_awready_o;
         @(negedge clk);
      end
      axi_awvalid_i = 1'b0;
      if (!ok) hung = 1'b1;
   endtask

   task automatic axi_w(input logic [31:0] d, input logic [3:0] s, input logic last);
      bit ok = 1'b0;
      axi_wvalid_i = 1'b1; axi_wdata_i = d; axi_wstrb_i = s; axi_wlast_i = last;
      for (int c = 0; c < 100 && !ok; c++) begin
         #1 ok = axi_wready_o;
         @(negedge clk);
      end
      axi_wvalid_i = 1'b0;
      if (!ok) hung = 1'b1;
   endtask

   task automatic axi_b(output logic [1:0] resp, output logic [3:0] id);
      bit got = 1'b0;
      resp = 2'bxx; id = 4'hx;
      axi_bready_i = 1'b1;
      for (int c = 0; c < 100 && !got; c++) begin
         if (axi_bvalid_o) begin
            resp = axi_bresp_o; id = axi_bid_o; got = 1'b1;
         end
         @(negedge clk);
      end
      axi_bready_i = 1'b0;
      if (!got) hung = 1'b1;
   endtask

   task automatic axi_r_collect(input int nbeats);
      r_n = 0;
      axi_rready_i = 1'b1;
      for (int c = 0; c < 400 && r_n < nbeats; c++) begin
         if (axi_rvalid_o) begin
            r_data[r_n] = axi_rdata_o; r_resp[r_n] = axi_rresp_o;
            r_last[r_n] = axi_rlast_o; r_id[r_n] = axi_rid_o;
            r_last_cyc = ncyc;
            r_n++;
         end
         @(negedge clk);
      end
      axi_rready_i = 1'b0;
      if (r_n < nbeats) hung = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if ({axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, axi_rlast_o} !== 6'b0) begin
         bad++; $display("FAIL reset_axi_ctrl got=%b want=000000", {axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, axi_rlast_o}); end
      total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b0) begin
         bad++; $display("FAIL reset_wb_ctrl got=%b want=000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
      total++; if (axi_rdata_o !== 32'h0) begin
         bad++; $display("FAIL reset_rdata got=%h want=00000000", axi_rdata_o); end
      total++; if (wb_addr_o !== 32'h0 || wb_data_o !== 32'h0) begin
         bad++; $display("FAIL reset_wb_addr_data got=%h/%h want=0/0", wb_addr_o, wb_data_o); end
      total++; if ({axi_rresp_o, axi_bresp_o} !== 4'b0) begin
         bad++; $display("FAIL reset_resp got=%b want=0000", {axi_rresp_o, axi_bresp_o}); end
      total++; if ({axi_rid_o, axi_bid_o} !== 8'h0) begin
         bad++; $display("FAIL reset_ids got=%h want=00", {axi_rid_o, axi_bid_o}); end
      total++; if (wb_sel_o !== 4'h0) begin
         bad++; $display("FAIL reset_sel got=%h want=0", wb_sel_o); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: done");
   endtask

   task automatic test_single_read();
      int base;
      int s0;
      hung = 1'b0; wait_cfg = 2; rd_fixed = 1'b1;
      base = q_addr.size(); s0 = stb_cycles;
      axi_ar(32'h100, 4'hA, 8'd0, 2'b01);
      axi_r_collect(1);
      total++; if (r_n !== 1) begin bad++; $display("FAIL single_beats got=%0d want=1", r_n); end
      total++; if (r_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h want=deadbeef", r_data[0]); end
      total++; if (r_last[0] !== 1'b1) begin bad++; $display("FAIL single_rlast got=%b want=1", r_last[0]); end
      total++; if (r_resp[0] !== 2'b00) begin bad++; $display("FAIL single_rresp got=%b want=00", r_resp[0]); end
      total++; if (r_id[0] !== 4'hA) begin bad++; $display("FAIL single_rid got=%h want=a", r_id[0]); end
      total++; if (q_addr.size() - base !== 1) begin bad++; $display("FAIL single_wb_beats got=%0d want=1", q_addr.size() - base); end
      else begin
         total++; if (q_addr[base] !== 32'h100) begin bad++; $display("FAIL single_wb_addr got=%h want=00000100", q_addr[base]); end
         total++; if (q_sel[base] !== 4'hF || q_we[base] !== 1'b0) begin bad++; $display("FAIL single_wb_sel_we got=%h/%b want=f/0", q_sel[base], q_we[base]); end
      end
      total++; if (stb_cycles - s0 !== 3) begin bad++; $display("FAIL single_stb_cycles got=%0d want=3", stb_cycles - s0); end
      total++; if (hung !== 1'b0) begin bad++; $display("FAIL single_hang got=%b want=0", hung); end
      $display("single_read: rdata=%h rresp=%b rid=%h", r_data[0], r_resp[0], r_id[0]);
   endtask

   task automatic test_incr_read();
      int base;
      int c0;
      hung = 1'b0; wait_cfg = 0; rd_fixed = 1'b0;
      base = q_addr.size();
      axi_ar(32'h1000, 4'h1, 8'd7, 2'b01);
      c0 = ncyc;
      axi_r_collect(8);
      total++; if (q_addr.size() - base !== 8) begin bad++; $display("FAIL incr_wb_beats got=%0d want=8", q_addr.size() - base); end
      else begin
         for (int i = 0; i < 8; i++) begin
            total++; if (q_addr[base+i] !== 32'h1000 + 32'(4*i)) begin
               bad++; $display("FAIL incr_addr[%0d] got=%h want=%h", i, q_addr[base+i], 32'h1000 + 32'(4*i)); end
            total++; if (r_data[i] !== ((32'h1000 + 32'(4*i)) ^ 32'h5A5A0000)) begin
               bad++; $display("FAIL incr_rdata[%0d] got=%h want=%h", i, r_data[i], (32'h1000 + 32'(4*i)) ^ 32'h5A5A0000); end
            total++; if (r_last[i] !== (i == 7)) begin
               bad++; $display("FAIL incr_rlast[%0d] got=%b want=%b", i, r_last[i], (i == 7)); end
         end
      end
      total++; if (r_last_cyc - c0 !== 15) begin bad++; $display("FAIL incr_latency got=%0d want=15", r_last_cyc - c0); end
      total++; if (hung !== 1'b0) begin bad++; $display("FAIL incr_hang got=%b want=0", hung); end
      $display("incr_read: beats=%0d cycles=%0d", r_n, r_last_cyc - c0);
   endtask

   task automatic test_wrap_read();
      int base;
      hung = 1'b0; wait_cfg = 1; rd_fixed = 1'b0;
      base = q_addr.size();
      axi_ar(32'h2018, 4'h2, 8'd7, 2'b10);
      axi_r_collect(8);
      total++; if (q_addr.size() - base !== 8) begin bad++; $display("FAIL wrap_wb_beats got=%0d want=8", q_addr.size() - base); end
      else begin
         for (int i = 0; i < 8; i++) begin
            total++; if (q_addr[base+i] !== WRAP_EXP[i]) begin
               bad++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, q_addr[base+i], WRAP_EXP[i]); end
         end
      end
      total++; if (r_last[7] !== 1'b1 || r_last[6] !== 1'b0) begin bad++; $display("FAIL wrap_rlast got=%b%b want=10", r_last[7], r_last[6]); end
      total++; if (hung !== 1'b0) begin bad++; $display("FAIL wrap_hang got=%b want=0", hung); end
      $display("wrap_read: beats=%0d", r_n);
   endtask

   task automatic test_write();
      int base;
      logic [1:0] resp;
      logic [3:0] id;
      hung = 1'b0; wait_cfg = 1;
      base = q_addr.size();
      axi_aw(32'h40, 4'h6, 8'd1, 2'b01);
      axi_w(32'h11223344, 4'b0011, 1'b0);
      axi_w(32'h55667788, 4'b1100, 1'b1);
      axi_b(resp, id);
      total++; if (q_addr.size() - base !== 2) begin bad++; $display("FAIL write_wb_beats got=%0d want=2", q_addr.size() - base); end
      else begin
         total++; if (q_addr[base] !== 32'h40 || q_addr[base+1] !== 32'h44) begin
            bad++; $display("FAIL write_addr got=%h,%h want=00000040,00000044", q_addr[base], q_addr[base+1]); end
         total++; if (q_sel[base] !== 4'b0011 || q_sel[base+1] !== 4'b1100) begin
            bad++; $display("FAIL write_sel got=%b,%b want=0011,1100", q_sel[base], q_sel[base+1]); end
         total++; if (q_data[base] !== 32'h11223344 || q_data[base+1] !== 32'h55667788) begin
            bad++; $display("FAIL write_data got=%h,%h want=11223344,55667788", q_data[base], q_data[base+1]); end
         total++; if (q_we[base] !== 1'b1 || q_we[base+1] !== 1'b1) begin
            bad++; $display("FAIL write_we got=%b%b want=11", q_we[base], q_we[base+1]); end
      end
      total++; if (resp !== 2'b00) begin bad++; $display("FAIL write_bresp got=%b want=00", resp); end
      total++; if (id !== 4'h6) begin bad++; $display("FAIL write_bid got=%h want=6", id); end
      $display("write: bresp=%b bid=%h", resp, id);
      // Early wlast on beat 0 must be reported as SLVERR.
      axi_aw(32'h40, 4'h7, 8'd1, 2'b01);
      axi_w(32'hAAAA0000, 4'b0011, 1'b1);
      axi_w(32'hBBBB0000, 4'b1100, 1'b1);
      axi_b(resp, id);
      total++; if (resp !== 2'b10) begin bad++; $display("FAIL write_err_bresp got=%b want=10", resp); end
      total++; if (id !== 4'h7) begin bad++; $display("FAIL write_err_bid got=%h want=7", id); end
      total++; if (hung !== 1'b0) begin bad++; $display("FAIL write_hang got=%b want=0", hung); end
      $display("write_err: bresp=%b bid=%h", resp, id);
   endtask

   task automatic test_arbitration();
      int base;
      bit seen;
      logic [1:0] resp;
      logic [3:0] id;
      hung = 1'b0; wait_cfg = 0; rd_fixed = 1'b0;
      apply_reset();
      base = q_addr.size();
      axi_awvalid_i = 1'b1; axi_awaddr_i = 32'h80; axi_awid_i = 4'h3; axi_awlen_i = 8'd0; axi_awburst_i = 2'b01;
      axi_arvalid_i = 1'b1; axi_araddr_i = 32'h200; axi_arid_i = 4'h5; axi_arlen_i = 8'd0; axi_arburst_i = 2'b01;
      #1;
      total++; if ({axi_awready_o, axi_arready_o} !== 2'b10) begin
         bad++; $display("FAIL arb_tie1 got=%b want=10", {axi_awready_o, axi_arready_o}); end
      @(negedge clk);
      axi_awaddr_i = 32'h84; axi_awid_i = 4'h4;
      axi_w(32'hCAFE0001, 4'hF, 1'b1);
      axi_b(resp, id);
      total++; if (id !== 4'h3 || resp !== 2'b00) begin bad++; $display("FAIL arb_b1 got=%h/%b want=3/00", id, resp); end
      axi_awvalid_i = 1'b1; axi_arvalid_i = 1'b1;
      #1;
      total++; if ({axi_awready_o, axi_arready_o} !== 2'b01) begin
         bad++; $display("FAIL arb_tie2 got=%b want=01", {axi_awready_o, axi_arready_o}); end
      axi_ar(32'h200, 4'h5, 8'd0, 2'b01);
      axi_awvalid_i = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (axi_rvalid_o) seen = 1'b1;
         else @(negedge clk);
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL arb_rvalid got=%b want=1", seen); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++; if (axi_rvalid_o !== 1'b1 || axi_rdata_o !== 32'h5A5A0200 || axi_rid_o !== 4'h5) begin
            bad++; $display("FAIL arb_hold[%0d] got=%b/%h/%h want=1/5a5a0200/5", k, axi_rvalid_o, axi_rdata_o, axi_rid_o); end
      end
      axi_r_collect(1);
      total++; if (r_data[0] !== 32'h5A5A0200) begin bad++; $display("FAIL arb_rdata got=%h want=5a5a0200", r_data[0]); end
      axi_aw(32'h84, 4'h4, 8'd0, 2'b01);
      axi_w(32'hCAFE0002, 4'hF, 1'b1);
      axi_b(resp, id);
      total++; if (id !== 4'h4 || resp !== 2'b00) begin bad++; $display("FAIL arb_b2 got=%h/%b want=4/00", id, resp); end
      total++; if (q_addr.size() - base !== 3) begin bad++; $display("FAIL arb_wb_beats got=%0d want=3", q_addr.size() - base); end
      else begin
         total++; if (q_addr[base] !== 32'h80 || q_addr[base+1] !== 32'h200 || q_addr[base+2] !== 32'h84) begin
            bad++; $display("FAIL arb_order got=%h,%h,%h want=00000080,00000200,00000084", q_addr[base], q_addr[base+1], q_addr[base+2]); end
      end
      total++; if (hung !== 1'b0) begin bad++; $display("FAIL arb_hang got=%b want=0", hung); end
      $display("arbitration: order checked");
   endtask

   task automatic test_timeout();
      int s0;
      hung = 1'b0; slave_en = 1'b0;
      s0 = stb_cycles;
      axi_ar(32'h300, 4'h2, 8'd0, 2'b01);
      axi_r_collect(1);
      slave_en = 1'b1;
      total++; if (r_resp[0] !== 2'b10) begin bad++; $display("FAIL tmo_rresp got=%b want=10", r_resp[0]); end
      total++; if (r_data[0] !== 32'h0) begin bad++; $display("FAIL tmo_rdata got=%h want=00000000", r_data[0]); end
      total++; if (r_last[0] !== 1'b1) begin bad++; $display("FAIL tmo_rlast got=%b want=1", r_last[0]); end
      total++; if (stb_cycles - s0 !== 16) begin bad++; $display("FAIL tmo_stb_cycles got=%0d want=16", stb_cycles - s0); end
      total++; if (hung !== 1'b0) begin bad++; $display("FAIL tmo_hang got=%b want=0", hung); end
      $display("timeout: rresp=%b stb_cycles=%0d", r_resp[0], stb_cycles - s0);
   endtask

   task automatic test_reset_mid_burst();
      bit seen = 1'b0;
      hung = 1'b0; wait_cfg = 20;
      axi_aw(32'h400, 4'h9, 8'd1, 2'b01);
      axi_w(32'h12345678, 4'hF, 1'b0);
      total++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) begin
         bad++; $display("FAIL midrst_in_bus got=%b%b want=11", wb_cyc_o, wb_we_o); end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin
         bad++; $display("FAIL midrst_release got=%b want=00", {wb_cyc_o, wb_stb_o}); end
      rst_n = 1'b1;
      axi_bready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (axi_bvalid_o) seen = 1'b1;
         @(negedge clk);
      end
      axi_bready_i = 1'b0;
      wait_cfg = 0;
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_bvalid got=%b want=0", seen); end
      total++; if (hung !== 1'b0) begin bad++; $display("FAIL midrst_hang got=%b want=0", hung); end
      $display("reset_mid_burst: bvalid_seen=%b", seen);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_incr_read();
      test_wrap_read();
      test_write();
      test_arbitration();
      test_timeout();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi4_wishbone_bridge.md
Name: axi4_wishbone_bridge

Overview:
- AXI4 slave to Wishbone classic master bridge. Connects one biriscv AXI master port (instruction or data) to one Controller Wishbone port (core_* or data_mem_*).
- Supports INCR, FIXED and WRAP bursts, one outstanding transaction, and a configurable per-beat ack timeout.
- Two instances sit between riscv_top and Controller inside processorci_top.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; STRB_W=DATA_W/8)
TIMEOUT_CYCLES, 1024, cycles to wait for wb_ack per beat; 0 disables timeout

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  synchronous active-low reset
axi_awvalid_i, axi_awready_o  in/out  1  AW handshake
axi_awaddr_i  in  ADDR_W  write start address
axi_awid_i  in  ID_W  write ID
axi_awlen_i  in  8  beats-1
axi_awburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
axi_wvalid_i, axi_wready_o  in/out  1  W handshake
axi_wdata_i  in  DATA_W  write data
axi_wstrb_i  in  STRB_W  byte strobes
axi_wlast_i  in  1  last write beat
axi_bvalid_o, axi_bready_i  out/in  1  B handshake
axi_bresp_o  out  2  write response
axi_bid_o  out  ID_W  echoed awid
axi_arvalid_i, axi_arready_o  in/out  1  AR handshake
axi_araddr_i  in  ADDR_W  read start address
axi_arid_i  in  ID_W  read ID
axi_arlen_i  in  8  beats-1
axi_arburst_i  in  2  burst type
axi_rvalid_o, axi_rready_i  out/in  1  R handshake
axi_rdata_o  out  DATA_W  read data
axi_rresp_o  out  2  read response
axi_rid_o  out  ID_W  echoed arid
axi_rlast_o  out  1  last read beat
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle/strobe/write
wb_addr_o  out  ADDR_W  word-aligned beat address
wb_data_o  out  DATA_W  write data
wb_sel_o  out  STRB_W  byte select (all ones on reads)
wb_data_i  in  DATA_W  read data
wb_ack_i  in  1  Wishbone ack

Behaviour:
- Reset (rst_n low at clk edge): state IDLE. All valid/ready/cyc/stb/we outputs 0. Data, address, id, resp outputs 0. Round-robin pointer set to favour write.
- FSM states: IDLE, RD_BUS, RD_RESP, WR_DATA, WR_BUS, WR_RESP.
- IDLE:
  - awready_o=arready_o=1 only for the channel being granted that cycle (combinational grant).
  - If both awvalid and arvalid: grant alternates; after a write the next tie goes to read, and vice versa.
  - On a grant, latch addr, id, len, burst; clear beat counter and error flag; go RD_BUS or WR_DATA.
- RD_BUS:
  - cyc=stb=1, we=0, sel=all ones, addr=current&~3.
  - On ack: rdata<=wb_data_i, rresp=OKAY; drop cyc/stb next cycle; go RD_RESP.
  - On timeout: rdata=0, rresp=SLVERR(2'b10); go RD_RESP.
- RD_RESP:
  - rvalid=1; rlast=(beat==len).
  - On rready: if last, go IDLE; else advance address, beat++, go RD_BUS.
  - rdata/rresp/rid stay stable while rvalid && !rready.
- WR_DATA: wready=1. On wvalid, latch wdata/wstrb. Set error flag if (wlast != (beat==len)). Go WR_BUS.
- WR_BUS:
  - cyc=stb=we=1, sel=latched wstrb.
  - Timeout sets error flag and ends the beat.
  - After ack/timeout: if beat==len, go WR_RESP; else advance address, beat++, go WR_DATA.
- WR_RESP: bvalid=1, bresp=error?SLVERR:OKAY, bid=latched id. On bready, go IDLE.
- Address advance:
  - FIXED: unchanged.
  - INCR: +4; 32-bit wrap-around is allowed.
  - WRAP: window = (len+1)*4 bytes, aligned to the window size; addr = base | ((addr+4) & (window-1)).
  - WRAP with len not in {1,3,7,15} is treated as INCR.
  - burst 2'b11 is treated as INCR.
- Timeout counter: resets at each stb assertion; fires when count==TIMEOUT_CYCLES-1 without ack. Disabled when TIMEOUT_CYCLES=0.
- Wishbone timing:
  - stb is held until ack; an ack received while stb=0 is ignored.
  - Minimum beat latency is 1 cycle bus + 1 cycle response, i.e. 2 cycles per beat at zero-wait Wishbone.
- rst_n low mid-burst aborts immediately: bus released next edge, no response issued.

Decomposition:
- Package axi_wb_pkg: state enum, burst constants (BURST_FIXED/INCR/WRAP), resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), and a function next_addr(addr,len,burst).
- No sub-module is needed.
- Optional sub-module wb_timeout_counter (counter + fire flag) if reused by the Controller.

Test Plan:
- Single read, araddr=0x100, len=0, INCR; slave returns 0xDEADBEEF after 2 waits -> one R beat, rdata=0xDEADBEEF, rlast=1, rresp=0, rid=arid.
- INCR read, araddr=0x1000, len=7 -> Wishbone addrs 0x1000..0x101C in order; 8 R beats, rlast on the 8th only.
- WRAP read, araddr=0x2018, len=7 -> addrs 0x2018, 0x201C, 0x2000..0x2014.
- Write, awaddr=0x40, len=1, wstrb 4'b0011 then 4'b1100 -> Wishbone writes to 0x40/0x44 with those sel values; bresp=OKAY; bid=awid. The same write with wlast on beat 0 -> bresp=SLVERR.
- Simultaneous awvalid and arvalid twice in a row from reset -> write granted first, then read. rready held low 5 cycles -> rdata stable throughout.
- No wb_ack with TIMEOUT_CYCLES=16 -> R beat after 16 stb cycles with rresp=SLVERR, rdata=0. rst_n pulsed low during WR_BUS -> cyc=0 next cycle, bvalid never asserted.
